lc3_mem_port: RTL and testbench
===============================

LC3_MEM_PORT -- requirements
Module: lc3_mem_port

Interface
- REQ-001: Parameters (name, default, meaning), one per line:
  - DW, 16, data width in bits.
  - AW, 16, address width in bits.
  - TIMEOUT, 15, maximum number of wait cycles on mem_ready before an access aborts.
- REQ-002: clk  input  1  clock; all state changes on the rising edge.
- REQ-003: reset  input  1  reset, asynchronous, active-high.
- REQ-004: cmd_valid  input  1  command present.
- REQ-005: cmd_ready  output  1  port can accept a command.
- REQ-006: cmd_op  input  2  operation code: 00 read, 01 write, 10 read-indirect, 11 write-indirect.
- REQ-007: cmd_addr  input  AW  direct address, or pointer address for indirect ops.
- REQ-008: cmd_wdata  input  DW  write data.
- REQ-009: rsp_valid  output  1  one-cycle completion pulse.
- REQ-010: rsp_rdata  output  DW  read result; 0 for writes and errors.
- REQ-011: rsp_err  output  1  access aborted by timeout; qualified by rsp_valid.
- REQ-012: mem_req  output  1  memory access request.
- REQ-013: mem_we  output  1  write strobe, qualified by mem_req.
- REQ-014: mem_addr  output  AW  memory address.
- REQ-015: mem_wdata  output  DW  memory write data.
- REQ-016: mem_rdata  input  DW  memory read data; valid while mem_ready=1.
- REQ-017: mem_ready  input  1  memory completes the current access this cycle.
- REQ-018: busy  output  1  high in every state except IDLE.

Function
- REQ-019: FSM states: IDLE, PTR, DATA, RESP.
- REQ-020: cmd_ready=1 only in IDLE.
- REQ-021: A command is accepted when cmd_valid & cmd_ready; op, address and wdata are latched at acceptance.
- REQ-022: On acceptance, op 10 or 11 goes to PTR; op 00 or 01 goes to DATA.
- REQ-023: In PTR, the block holds mem_req=1, mem_we=0, mem_addr=latched address.
- REQ-024: On mem_ready in PTR, the pointer is mem_rdata[AW-1:0] (zero-extended when AW>DW) and the FSM goes to DATA.
- REQ-025: In DATA, the block holds mem_req=1, mem_we=1 for write ops, mem_addr=effective address, mem_wdata=latched wdata.
- REQ-026: On mem_ready in DATA, read ops capture mem_rdata, and the FSM goes to RESP.
- REQ-027: In RESP, rsp_valid=1 for exactly one cycle, then the FSM returns to IDLE; there is no response backpressure.
- REQ-028: mem_req, mem_we, mem_addr and mem_wdata stay constant from assertion until the cycle mem_ready is sampled high; mem_req deasserts in the following cycle.
- REQ-029: mem_req=0 in IDLE and RESP; mem_ready is ignored when mem_req=0.
- REQ-030: Latency with zero wait states, from the acceptance edge to rsp_valid high: 2 cycles direct, 3 cycles indirect.
- REQ-031: Each wait cycle adds one cycle of latency.
- REQ-032: cmd_valid is ignored while busy=1; no queuing.
- REQ-033: Back-to-back: a new command may be accepted in the cycle after RESP.

Reset
- REQ-034: Reset forces state=IDLE, cmd_ready=1, busy=0, rsp_valid=0, rsp_err=0, mem_req=0, mem_we=0.
- REQ-035: Reset forces rsp_rdata, mem_addr, mem_wdata and all latches to 0.
- REQ-036: Reset mid-access abandons the access with no response; the first command after reset deassertion is accepted normally.

Configuration
- REQ-037: Macro LC3_MEM_PORT_TIMEOUT_EN defined: a wait counter clears on each mem_req rising and counts cycles with mem_req=1 & mem_ready=0.
- REQ-038: With the macro defined, reaching TIMEOUT aborts the access: mem_req drops, the FSM goes to RESP with rsp_err=1 and rsp_rdata=0.
- REQ-039: A pointer-phase timeout skips DATA entirely.
- REQ-040: mem_ready arriving in the same cycle the count reaches TIMEOUT counts as success.
- REQ-041: Macro not defined: the block waits indefinitely for mem_ready and rsp_err is tied to 0.

Structure
- REQ-042: Shared package lc3_pkg holds typedef mem_op_t (MOP_RD, MOP_WR, MOP_RDI, MOP_WRI) and typedef mem_port_state_t.
- REQ-043: The wait counter is sub-module lc3_wait_timer (width $clog2(TIMEOUT+1), inputs start/run, output expired), instantiated only under LC3_MEM_PORT_TIMEOUT_EN.

Verification
- REQ-044: Direct read, cmd_addr=0x0030, memory returns 0x1234 with 0 waits -> mem_req one cycle at addr 0x0030 with we=0; rsp_valid 2 cycles after acceptance; rsp_rdata=0x1234, rsp_err=0.
- REQ-045: Write-indirect, cmd_addr=0x0010, mem[0x0010]=0x0200, wdata=0xBEEF, 2 waits per access -> pointer read at 0x0010, then write 0xBEEF to 0x0200; rsp_valid 7 cycles after acceptance.
- REQ-046: cmd_valid held high continuously with 4 queued commands -> exactly 4 responses; cmd_ready low whenever busy; mem request signals stable across all wait cycles.
- REQ-047: With the macro defined and TIMEOUT=15, mem_ready never asserted during the pointer phase of a read-indirect -> abort after 15 wait cycles; rsp_err=1, rsp_rdata=0; no DATA-phase request issued.
- REQ-048: reset pulsed during DATA of a write with mem_ready low -> all outputs at reset values; no rsp_valid; next read of 0x0030 completes normally.
- REQ-049: AW=20, DW=16, read-indirect with pointer 0xFFFF -> data access at address 0x0FFFF (zero-extended).

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 memory port: operation codes, port FSM states
// and small decode helpers for the operation field.
package lc3_pkg;

    typedef enum logic [1:0] {
        MOP_RD  = 2'b00,
        MOP_WR  = 2'b01,
        MOP_RDI = 2'b10,
        MOP_WRI = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PTR  = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } mem_port_state_t;

    // Indirect ops fetch a pointer before the data access.
    function automatic logic op_is_indirect(input mem_op_t op);
        return op[1];
    endfunction

    // Write ops drive mem_we in the data phase.
    function automatic logic op_is_write(input mem_op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/lc3_wait_timer.sv
// Wait-state counter for the LC-3 memory port. Cleared by start, counts
// cycles where run is high, and flags expiry in the cycle the count would
// reach TIMEOUT. run is low whenever the memory answers, so an answer in
// that last cycle always wins over expiry.
module lc3_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic expired
);
    import lc3_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);
    localparam logic [TW-1:0] LAST  = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_r;

    // Restart on each new access, otherwise count stalled cycles up to the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {TW{1'b0}};
        end else if (start) begin
            cnt_r <= {TW{1'b0}};
        end else if (run && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = run && (cnt_r == LAST);

endmodule

// File: rtl/lc3_mem_port.sv
// LC-3 memory port: accepts direct/indirect read/write commands, runs one or
// two memory accesses with a ready handshake and returns a one-cycle response.
// All outputs are registered; the response pulse therefore appears in the
// cycle after the FSM passes through RESP, which is also the first cycle a
// new command can be accepted.
// Optional build macro LC3_MEM_PORT_TIMEOUT_EN: aborts an access that waits
// TIMEOUT cycles on mem_ready and reports it through rsp_err.
module lc3_mem_port #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy
);
    import lc3_pkg::*;

    mem_port_state_t state_r, state_nx_s;
    mem_op_t         op_r, op_nx_s;
    logic            err_r, err_nx_s;
    logic [DW-1:0]   rdata_r, rdata_nx_s;
    logic            cmd_ready_r, busy_r, rsp_valid_r, rsp_err_r;
    logic [DW-1:0]   rsp_rdata_r;
    logic            mem_req_r, mem_req_nx_s, mem_we_r, mem_we_nx_s;
    logic [AW-1:0]   mem_addr_r, mem_addr_nx_s, ptr_s;
    logic [DW-1:0]   mem_wdata_r, mem_wdata_nx_s;
    logic            start_s, expired_s;

    // Pointer read back from memory is zero-extended or truncated to AW.
    generate
        if (AW > DW) begin : g_ptr_ext
            assign ptr_s = {{(AW-DW){1'b0}}, mem_rdata};
        end else begin : g_ptr_trunc
            assign ptr_s = mem_rdata[AW-1:0];
        end
    endgenerate

`ifdef LC3_MEM_PORT_TIMEOUT_EN
    lc3_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (start_s),
        .run     (mem_req_r & ~mem_ready),
        .expired (expired_s)
    );
`else
    // Without the timer an access waits for mem_ready indefinitely.
    logic unused_s;
    assign unused_s  = start_s | (TIMEOUT == 0);
    assign expired_s = 1'b0;
`endif

    // Next-state and next-value logic for the access sequencer.
    always_comb begin
        state_nx_s     = state_r;
        op_nx_s        = op_r;
        err_nx_s       = err_r;
        rdata_nx_s     = rdata_r;
        mem_req_nx_s   = mem_req_r;
        mem_we_nx_s    = mem_we_r;
        mem_addr_nx_s  = mem_addr_r;
        mem_wdata_nx_s = mem_wdata_r;
        start_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    op_nx_s        = mem_op_t'(cmd_op);
                    err_nx_s       = 1'b0;
                    rdata_nx_s     = {DW{1'b0}};
                    mem_addr_nx_s  = cmd_addr;
                    mem_wdata_nx_s = cmd_wdata;
                    mem_req_nx_s   = 1'b1;
                    start_s        = 1'b1;
                    if (op_is_indirect(mem_op_t'(cmd_op))) begin
                        state_nx_s  = PTR;
                        mem_we_nx_s = 1'b0;
                    end else begin
                        state_nx_s  = DATA;
                        mem_we_nx_s = op_is_write(mem_op_t'(cmd_op));
                    end
                end else begin
                    mem_req_nx_s = 1'b0;
                    mem_we_nx_s  = 1'b0;
                end
            end
            PTR: begin
                if (mem_ready) begin
                    // Pointer handed straight to the data access; a new access starts.
                    state_nx_s    = DATA;
                    mem_addr_nx_s = ptr_s;
                    mem_we_nx_s   = op_is_write(op_r);
                    start_s       = 1'b1;
                end else if (expired_s) begin
                    state_nx_s   = RESP;
                    err_nx_s     = 1'b1;
                    mem_req_nx_s = 1'b0;
                    mem_we_nx_s  = 1'b0;
                end else begin
                    state_nx_s = PTR;
                end
            end
            DATA: begin
                if (mem_ready) begin
                    state_nx_s   = RESP;
                    rdata_nx_s   = op_is_write(op_r) ? {DW{1'b0}} : mem_rdata;
                    mem_req_nx_s = 1'b0;
                    mem_we_nx_s  = 1'b0;
                end else if (expired_s) begin
                    state_nx_s   = RESP;
                    err_nx_s     = 1'b1;
                    mem_req_nx_s = 1'b0;
                    mem_we_nx_s  = 1'b0;
                end else begin
                    state_nx_s = DATA;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s   = IDLE;
                mem_req_nx_s = 1'b0;
                mem_we_nx_s  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Command latches and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r        <= MOP_RD;
            err_r       <= 1'b0;
            rdata_r     <= {DW{1'b0}};
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DW{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
        end else begin
            op_r        <= op_nx_s;
            err_r       <= err_nx_s;
            rdata_r     <= rdata_nx_s;
            cmd_ready_r <= (state_nx_s == IDLE);
            busy_r      <= (state_nx_s != IDLE);
            rsp_valid_r <= (state_r == RESP);
            rsp_err_r   <= (state_r == RESP) && err_r;
            rsp_rdata_r <= (state_r == RESP) ? rdata_r : rsp_rdata_r;
            mem_req_r   <= mem_req_nx_s;
            mem_we_r    <= mem_we_nx_s;
            mem_addr_r  <= mem_addr_nx_s;
            mem_wdata_r <= mem_wdata_nx_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lc3_mem_port.sv
// Scoreboard bench for lc3_mem_port. Expected responses and memory accesses
// are derived from a reference memory when a command is driven, and checked
// when the DUT responds or completes an access. A second instance with
// AW=20 covers pointer zero-extension.
module tb_lc3_mem_port;
    import lc3_pkg::*;

    typedef struct { logic [15:0] rdata; logic err; int lat; } rsp_t;
    typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_addr = 16'h0, cmd_wdata = 16'h0;
    logic        rsp_valid, rsp_err, mem_req, mem_we, busy;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_ready = 1'b0;

    logic        c20_valid = 1'b0, c20_ready, r20_valid, r20_err, m20_req, m20_we, m20_ready, b20;
    logic [1:0]  c20_op = 2'b00;
    logic [19:0] c20_addr = 20'h0, m20_addr;
    logic [15:0] c20_wdata = 16'h0, r20_rdata, m20_wdata, m20_rdata;

    int n_chk = 0, n_pass = 0, cyc = 0, n_rsp = 0, req_cycles = 0, wait_cfg = 0;
    rsp_t exp_rsp_q[$];
    acc_t exp_acc_q[$];
    int   acc_cyc_q[$];
    logic [15:0] mem     [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    localparam int TO_LAT = 16;  // abort edge after 15 wait cycles, then RESP, then pulse

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lc3_mem_port #(.DW(16), .AW(16), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    assign m20_ready = m20_req;
    assign m20_rdata = (m20_addr == 20'h00040) ? 16'hFFFF : 16'hA5A5;

    lc3_mem_port #(.DW(16), .AW(20), .TIMEOUT(15)) dut20 (
        .clk(clk), .reset(reset), .cmd_valid(c20_valid), .cmd_ready(c20_ready),
        .cmd_op(c20_op), .cmd_addr(c20_addr), .cmd_wdata(c20_wdata),
        .rsp_valid(r20_valid), .rsp_rdata(r20_rdata), .rsp_err(r20_err),
        .mem_req(m20_req), .mem_we(m20_we), .mem_addr(m20_addr), .mem_wdata(m20_wdata),
        .mem_rdata(m20_rdata), .mem_ready(m20_ready), .busy(b20)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] rd_ref(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] rd_mem(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_ctl"}, {cmd_ready, busy, rsp_valid, rsp_err, mem_req, mem_we}, 64'h20);
        check_val({tag, "_data"}, {rsp_rdata, mem_addr, mem_wdata}, 64'h0);
    endtask

    // Push expectations for one command, then hold it until accepted.
    task automatic issue(input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic exp_err);
        rsp_t r;
        logic [15:0] eff;
        logic accepted;
        eff = addr;
        r.err = exp_err;
        r.rdata = 16'h0000;
        if (exp_err) begin
            r.lat = TO_LAT;
        end else begin
            if (op[1]) begin
                exp_acc_q.push_back('{we: 1'b0, addr: addr, wdata: wdata});
                eff = rd_ref(addr);
            end
            exp_acc_q.push_back('{we: op[0], addr: eff, wdata: wdata});
            if (op[0]) ref_mem[eff] = wdata;
            else r.rdata = rd_ref(eff);
            r.lat = op[1] ? 3 + 2 * wait_cfg : 2 + wait_cfg;
        end
        exp_rsp_q.push_back(r);
        cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        accepted = 1'b0;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge clk);
            accepted = cmd_ready;
        end
        if (!accepted) check_val("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        for (int t = 0; t < 400 && exp_rsp_q.size() != 0; t++) @(negedge clk);
        check_val("drain", exp_rsp_q.size(), 64'd0);
        @(posedge clk); #1;
    endtask

    // Response monitor: pop expected response on each pulse.
    always @(negedge clk) begin
        rsp_t r;
        int a;
        if (!reset) begin
            if (cmd_valid && cmd_ready) acc_cyc_q.push_back(cyc + 1);
            if (cmd_valid) check_val("ready_vs_busy", cmd_ready, !busy);
            if (rsp_valid) begin
                n_rsp++;
                if (exp_rsp_q.size() == 0 || acc_cyc_q.size() == 0) begin
                    check_val("spurious_rsp", 64'd1, 64'd0);
                end else begin
                    r = exp_rsp_q.pop_front();
                    a = acc_cyc_q.pop_front();
                    check_val("rsp_rdata", rsp_rdata, r.rdata);
                    check_val("rsp_err", rsp_err, r.err);
                    check_val("rsp_latency", cyc - a, r.lat);
                end
            end
        end
    end

    // Memory responder: wait_cfg stall cycles per access, logs completed accesses.
    always @(negedge clk) begin
        acc_t e;
        static acc_t cur;
        static int wcnt = 0;
        if (reset) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else begin
            if (mem_ready) begin
                if (cur.we) mem[cur.addr] = cur.wdata;
                if (exp_acc_q.size() == 0) begin
                    check_val("spurious_acc", 64'd1, 64'd0);
                end else begin
                    e = exp_acc_q.pop_front();
                    check_val("acc_we_addr", {cur.we, cur.addr}, {e.we, e.addr});
                    if (e.we) check_val("acc_wdata", cur.wdata, e.wdata);
                end
                wcnt = 0;
            end
            mem_ready = 1'b0;
            mem_rdata = 16'hDEAD;
            if (mem_req) begin
                req_cycles++;
                if (wcnt == 0) cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
                else check_val("req_stable", {mem_we, mem_addr, mem_wdata}, {cur.we, cur.addr, cur.wdata});
                if (wcnt >= wait_cfg) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd_mem(mem_addr);
                end
                wcnt++;
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] addrs [4];
        addrs[0] = 16'h0030; addrs[1] = 16'h0010; addrs[2] = 16'h0100; addrs[3] = 16'h0200;
        repeat (3) @(posedge clk);
        #1 check_reset_outs("por");
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Direct read, zero waits.
        preload(16'h0030, 16'h1234);
        wait_cfg = 0;
        issue(MOP_RD, 16'h0030, 16'h0000, 1'b0);
        drain();

        // Write-indirect, two waits per access, then read the target back.
        preload(16'h0010, 16'h0200);
        wait_cfg = 2;
        issue(MOP_WRI, 16'h0010, 16'hBEEF, 1'b0);
        drain();
        wait_cfg = 0;
        issue(MOP_RD, 16'h0200, 16'h0000, 1'b0);
        drain();

        // Four commands with cmd_valid held high throughout.
        wait_cfg = 1;
        base = n_rsp;
        issue(MOP_WR, 16'h0100, 16'h1111, 1'b0);
        issue(MOP_RD, 16'h0100, 16'h0000, 1'b0);
        issue(MOP_RDI, 16'h0010, 16'h0000, 1'b0);
        issue(MOP_WRI, 16'h0010, 16'h7777, 1'b0);
        drain();
        check_val("b2b_count", n_rsp - base, 64'd4);

        // Reset during a stalled direct write: no response, clean restart.
        wait_cfg = 1000;
        issue(MOP_WR, 16'h0050, 16'h5555, 1'b0);
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outs("mid_reset");
        exp_rsp_q.delete(); exp_acc_q.delete(); acc_cyc_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        wait_cfg = 0;
        issue(MOP_RD, 16'h0030, 16'h0000, 1'b0);
        drain();

`ifdef LC3_MEM_PORT_TIMEOUT_EN
        // Answer in the last allowed cycle still succeeds.
        wait_cfg = 14;
        issue(MOP_RD, 16'h0030, 16'h0000, 1'b0);
        drain();
        // Pointer phase never answered: abort, no data access.
        wait_cfg = 1000;
        req_cycles = 0;
        issue(MOP_RDI, 16'h0010, 16'h0000, 1'b1);
        drain();
        check_val("timeout_req_cycles", req_cycles, 64'd15);
`else
        // Without the timer a long stall still completes.
        wait_cfg = 20;
        issue(MOP_RD, 16'h0030, 16'h0000, 1'b0);
        drain();
`endif

        // Mixed commands with random waits.
        for (int i = 0; i < 8; i++) begin
            wait_cfg = $urandom_range(0, 3);
            op = 2'($urandom_range(0, 3));
            addr = addrs[$urandom_range(0, 3)];
            issue(op, addr, 16'($urandom), 1'b0);
            drain();
        end
        check_val("acc_leftover", exp_acc_q.size(), 64'd0);

        // AW=20: pointer 0xFFFF is zero-extended to 0x0FFFF.
        c20_op = MOP_RDI; c20_addr = 20'h00040; c20_valid = 1'b1;
        @(negedge clk) check_val("w20_ready", c20_ready, 64'd1);
        @(posedge clk); #1 c20_valid = 1'b0;
        @(negedge clk) check_val("w20_ptr", {m20_req, m20_we, m20_addr}, {2'b10, 20'h00040});
        @(negedge clk) check_val("w20_data", {m20_req, m20_we, m20_addr}, {2'b10, 20'h0FFFF});
        @(negedge clk);
        @(negedge clk) check_val("w20_rsp", {r20_valid, r20_err, r20_rdata}, {2'b10, 16'hA5A5});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
